// File: rtl/regbank_param.sv
// regbank_param: parametrised general-purpose register bank.
// Two registered read ports, one write port, register 0 hard-wired to zero,
// and a clear sequencer that zeroes registers 1..DEPTH-1 one per cycle.
// Optional macro REGBANK_BYPASS_EN: when defined, a write accepted on the
// same edge as a read of that address forwards datain to the read port.
// Without it, reads return the pre-write contents (read-before-write).
module regbank_param #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 32,
   parameter int AW    = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [AW-1:0]    RegLe1,
   input  logic [AW-1:0]    RegLe2,
   input  logic [AW-1:0]    RegEscr,
   input  logic             EscrReg,
   input  logic [WIDTH-1:0] datain,
   input  logic             clr,
   output logic [WIDTH-1:0] data1,
   output logic [WIDTH-1:0] data2,
   output logic             busy
);

   typedef enum logic {
      IDLE,
      CLEAR
   } state_t;

   localparam logic [AW-1:0] FIRST_IDX = AW'(1);
   localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);

   state_t           state;
   logic [AW-1:0]    idx;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             wr_hit;
   logic             wr_en;
   logic [WIDTH-1:0] rd1;
   logic [WIDTH-1:0] rd2;

   // Write qualification: only addresses 1..DEPTH-1 are writable, and never while clearing.
   always_comb begin
      // NOTE: combinational blocks use blocking '=' with a default first, so no latch is inferred.
      wr_hit = 1'b0;
      for (int i = 1; i < DEPTH; i++) begin
         if (RegEscr == AW'(i)) wr_hit = 1'b1;
      end
      wr_en = EscrReg & ~busy & wr_hit;
   end

   // Read muxes: index 0 and out-of-range addresses fall through to zero.
   always_comb begin
      rd1 = '0;
      rd2 = '0;
      for (int i = 1; i < DEPTH; i++) begin
         if (RegLe1 == AW'(i)) rd1 = mem[i];
         if (RegLe2 == AW'(i)) rd2 = mem[i];
      end
`ifdef REGBANK_BYPASS_EN
      // wr_en already excludes address 0, out-of-range addresses and busy.
      if (wr_en && (RegLe1 == RegEscr)) rd1 = datain;
      if (wr_en && (RegLe2 == RegEscr)) rd2 = datain;
`endif
   end

   // Clear sequencer: IDLE waits for clr, CLEAR walks idx from 1 to DEPTH-1.
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
      if (!reset) begin
         state <= IDLE;
         idx   <= FIRST_IDX;
         busy  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (clr) begin
                  state <= CLEAR;
                  idx   <= FIRST_IDX;
                  busy  <= 1'b1;
               end
            end
            CLEAR: begin
               if (idx == LAST_IDX) begin
                  state <= IDLE;
                  idx   <= FIRST_IDX;
                  busy  <= 1'b0;
               end else begin
                  idx <= idx + FIRST_IDX;
               end
            end
            default: begin
               state <= IDLE;
               idx   <= FIRST_IDX;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Register storage: cleared by the sequencer or loaded by an accepted write.
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: the bank must read zero right after reset, so it is built from resettable flops, not a RAM macro.
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         for (int i = 1; i < DEPTH; i++) begin
            if (busy && (idx == AW'(i))) begin
               mem[i] <= '0;
            end else if (wr_en && (RegEscr == AW'(i))) begin
               mem[i] <= datain;
            end
         end
      end
   end

   // Registered read ports.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data1 <= '0;
         data2 <= '0;
      end else begin
         data1 <= rd1;
         data2 <= rd2;
      end
   end

endmodule

// File: tb/tb_regbank_param.sv
// tb_regbank_param: directed self-checking bench for regbank_param.
// Main instance uses the default 32x32 bank (AW=6); a second instance with
// DEPTH=20, AW=5 covers out-of-range addresses. Expected values for the
// same-cycle hazard depend on REGBANK_BYPASS_EN.
module tb_regbank_param;

`ifdef REGBANK_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  le1, le2, escr;
   logic        we;
   logic [31:0] din;
   logic        clr;
   logic [31:0] d1, d2;
   logic        busy;

   logic [4:0]  le1_b, le2_b, escr_b;
   logic        we_b;
   logic [31:0] din_b;
   logic        clr_b;
   logic [31:0] d1_b, d2_b;
   logic        busy_b;

   int errors = 0;
   int checks = 0;
   int cnt;

   typedef struct {
      logic        we;
      logic [5:0]  wa;
      logic [31:0] wd;
      logic [5:0]  r1;
      logic [5:0]  r2;
      logic [31:0] e1;
      logic [31:0] e2;
   } vec_t;

   vec_t vecs [9];

   always #5 clk = ~clk;

   regbank_param dut (
      .clk(clk), .reset(reset),
      .RegLe1(le1), .RegLe2(le2), .RegEscr(escr), .EscrReg(we),
      .datain(din), .clr(clr),
      .data1(d1), .data2(d2), .busy(busy)
   );

   regbank_param #(.WIDTH(32), .DEPTH(20), .AW(5)) dut20 (
      .clk(clk), .reset(reset),
      .RegLe1(le1_b), .RegLe2(le2_b), .RegEscr(escr_b), .EscrReg(we_b),
      .datain(din_b), .clr(clr_b),
      .data1(d1_b), .data2(d2_b), .busy(busy_b)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Counts cycles busy stays high; optionally pokes a write and a stray clr mid-sequence.
   task automatic count_busy(output int n);
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         n++;
         we  = (n == 5);
         clr = (n == 10);
         tick();
         if (n == 1) check("read_during_clear_r31", d1, 32'h0000_011F);
      end
      we  = 1'b0;
      clr = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      reset = 1'b0;
      le1 = '0; le2 = '0; escr = '0; we = 1'b0; din = '0; clr = 1'b0;
      le1_b = '0; le2_b = '0; escr_b = '0; we_b = 1'b0; din_b = '0; clr_b = 1'b0;

      vecs[0] = '{1'b1, 6'd5,  32'hDEADBEEF, 6'd0,  6'd1,  32'h0,        32'h0};
      vecs[1] = '{1'b1, 6'd0,  32'h00001234, 6'd5,  6'd5,  32'hDEADBEEF, 32'hDEADBEEF};
      vecs[2] = '{1'b1, 6'd7,  32'h00000011, 6'd0,  6'd5,  32'h0,        32'hDEADBEEF};
      vecs[3] = '{1'b0, 6'd9,  32'hFFFFFFFF, 6'd7,  6'd9,  32'h00000011, 32'h0};
      vecs[4] = '{1'b1, 6'd31, 32'hCAFEF00D, 6'd9,  6'd0,  32'h0,        32'h0};
      vecs[5] = '{1'b1, 6'd40, 32'h55555555, 6'd31, 6'd7,  32'hCAFEF00D, 32'h00000011};
      vecs[6] = '{1'b1, 6'd63, 32'h00000066, 6'd40, 6'd63, 32'h0,        32'h0};
      vecs[7] = '{1'b1, 6'd1,  32'h00000001, 6'd63, 6'd31, 32'h0,        32'hCAFEF00D};
      vecs[8] = '{1'b0, 6'd2,  32'h00000002, 6'd1,  6'd5,  32'h00000001, 32'hDEADBEEF};

      // Reset state.
      #12;
      check("reset_data1", d1, 32'h0);
      check("reset_data2", d2, 32'h0);
      check("reset_busy", {31'h0, busy}, 32'h0);
      reset = 1'b1;

      // Table-driven write/read vectors.
      for (int i = 0; i < 9; i++) begin
         we = vecs[i].we; escr = vecs[i].wa; din = vecs[i].wd;
         le1 = vecs[i].r1; le2 = vecs[i].r2;
         tick();
         check($sformatf("vec%0d_data1", i), d1, vecs[i].e1);
         check($sformatf("vec%0d_data2", i), d2, vecs[i].e2);
      end

      // Same-cycle read/write hazard on r7 (holds 0x11).
      we = 1'b1; escr = 6'd7; din = 32'hA5A5A5A5; le1 = 6'd7; le2 = 6'd0;
      tick();
      check("hazard_data1", d1, BYPASS ? 32'hA5A5A5A5 : 32'h00000011);
      check("hazard_data2", d2, 32'h0);
      we = 1'b0;
      tick();
      check("after_hazard_r7", d1, 32'hA5A5A5A5);
      // Write to r0 and to an out-of-range address never forward.
      we = 1'b1; escr = 6'd0; din = 32'h77; le1 = 6'd0; le2 = 6'd0;
      tick();
      check("no_bypass_r0", d1, 32'h0);
      escr = 6'd40; din = 32'h88; le1 = 6'd40;
      tick();
      check("no_bypass_oor", d1, 32'h0);
      we = 1'b0;

      // Fill r1..r31 with nonzero values.
      for (int i = 1; i < 32; i++) begin
         we = 1'b1; escr = 6'(i); din = 32'h100 + 32'(i);
         tick();
      end
      we = 1'b0; le1 = 6'd31; le2 = 6'd1;
      tick();
      check("fill_r31", d1, 32'h0000_011F);
      check("fill_r1", d2, 32'h0000_0101);

      // Clear: 31-cycle busy, write to r3 dropped, stray clr ignored.
      clr = 1'b1;
      tick();
      check("clear_busy_rise", {31'h0, busy}, 32'h1);
      clr = 1'b0; escr = 6'd3; din = 32'h0000_0BAD; le1 = 6'd31; le2 = 6'd3;
      count_busy(cnt);
      check("clear_busy_cycles", 32'(cnt), 32'd31);
      tick();
      check("clear_no_restart", {31'h0, busy}, 32'h0);
      for (int i = 0; i < 32; i += 2) begin
         le1 = 6'(i); le2 = 6'(i + 1);
         tick();
         check($sformatf("cleared_r%0d", i), d1, 32'h0);
         check($sformatf("cleared_r%0d", i + 1), d2, 32'h0);
      end

      // Reset asserted mid-clear.
      we = 1'b1; escr = 6'd20; din = 32'h2020;
      tick();
      escr = 6'd30; din = 32'h3030;
      tick();
      we = 1'b0; clr = 1'b1;
      tick();
      clr = 1'b0; le1 = 6'd20; le2 = 6'd30;
      repeat (10) tick();
      check("preabort_data1", d1, 32'h2020);
      check("preabort_data2", d2, 32'h3030);
      check("preabort_busy", {31'h0, busy}, 32'h1);
      #2 reset = 1'b0;
      #1;
      check("abort_data1", d1, 32'h0);
      check("abort_data2", d2, 32'h0);
      check("abort_busy", {31'h0, busy}, 32'h0);
      #1 reset = 1'b1;
      tick();
      check("postabort_r20", d1, 32'h0);
      check("postabort_r30", d2, 32'h0);
      check("postabort_busy", {31'h0, busy}, 32'h0);
      clr = 1'b1;
      tick();
      clr = 1'b0; escr = 6'd3; din = 32'h0000_0BAD; le1 = 6'd31; le2 = 6'd3;
      cnt = 0;
      while (busy === 1'b1 && cnt < 100) begin
         cnt++;
         tick();
      end
      check("reclear_busy_cycles", 32'(cnt), 32'd31);

      // Out-of-range on DEPTH=20, AW=5.
      we_b = 1'b1; escr_b = 5'd25; din_b = 32'h0000_BEEF;
      tick();
      escr_b = 5'd19; din_b = 32'h0000_1919; le1_b = 5'd25;
      tick();
      check("d20_read_25_early", d1_b, 32'h0);
      escr_b = 5'd20; din_b = 32'h0000_2020;
      tick();
      we_b = 1'b0; le1_b = 5'd25; le2_b = 5'd19;
      tick();
      check("d20_read_25", d1_b, 32'h0);
      check("d20_read_19", d2_b, 32'h0000_1919);
      le1_b = 5'd20;
      tick();
      check("d20_read_20", d1_b, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
